// File: rtl/z80_arb_pkg.sv
// rtl/z80_arb_pkg.sv - shared types and helpers for the Z80 bus-request arbiter
package z80_arb_pkg;

  localparam int MAX_NREQ    = 8;
  localparam int OWNER_W_MAX = 3;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GRANT,
    RELEASE,
    GAP
  } arb_state_t;

  // Owner index width; a single master still gets a 1-bit field.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_NREQ-1:0] onehot(input logic [OWNER_W_MAX-1:0] idx);
    logic [MAX_NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at or after ptr
module rr_pick #(
  parameter int NREQ = 2,
  parameter int OW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   ptr,
  output logic            valid,
  output logic [OW-1:0]   idx
);

  logic [OW-1:0] w_cand;

  // Scan from farthest to nearest so the candidate closest to ptr wins.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = OW'((int'(ptr) + k) % NREQ);
      if (req[w_cand]) begin
        valid = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/z80_bus_arbiter.sv
// rtl/z80_bus_arbiter.sv - round-robin owner of the Z80 nBUSRQ/nBUSACK handshake
module z80_bus_arbiter
  import z80_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int MAX_HOLD = 64,
  parameter int MIN_CPU  = 4
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [NREQ-1:0]             req,
  input  logic                        nBUSACK,
  output logic                        nBUSRQ,
  output logic [NREQ-1:0]             grant,
  output logic                        bus_oe,
  output logic [owner_w(NREQ)-1:0]    owner,
  output logic                        preempt
);

  localparam int OW = owner_w(NREQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int GW = $clog2(MIN_CPU + 1);

  arb_state_t      r_state;
  logic [OW-1:0]   r_winner;
  logic [OW-1:0]   r_ptr;
  logic [HW-1:0]   r_hold_cnt;
  logic [GW-1:0]   r_gap_cnt;
  logic            r_busrq_n;
  logic [NREQ-1:0] r_grant;
  logic            r_bus_oe;
  logic [OW-1:0]   r_owner;
  logic            r_preempt;

  arb_state_t      w_state_nxt;
  logic [OW-1:0]   w_winner_nxt;
  logic [OW-1:0]   w_ptr_nxt;
  logic [HW-1:0]   w_hold_nxt;
  logic [GW-1:0]   w_gap_nxt;
  logic            w_busrq_n_nxt;
  logic [NREQ-1:0] w_grant_nxt;
  logic            w_bus_oe_nxt;
  logic [OW-1:0]   w_owner_nxt;
  logic            w_preempt_nxt;

  logic            w_pick_valid;
  logic [OW-1:0]   w_pick_idx;
  logic            w_expire;

  rr_pick #(
    .NREQ (NREQ),
    .OW   (OW)
  ) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  assign w_expire = (r_hold_cnt == HW'(MAX_HOLD - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_winner   <= '0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
      r_busrq_n  <= 1'b1;
      r_grant    <= '0;
      r_bus_oe   <= 1'b0;
      r_owner    <= '0;
      r_preempt  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_winner   <= w_winner_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_busrq_n  <= w_busrq_n_nxt;
      r_grant    <= w_grant_nxt;
      r_bus_oe   <= w_bus_oe_nxt;
      r_owner    <= w_owner_nxt;
      r_preempt  <= w_preempt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_winner_nxt  = r_winner;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold_cnt;
    w_gap_nxt     = r_gap_cnt;
    w_busrq_n_nxt = r_busrq_n;
    w_grant_nxt   = r_grant;
    w_bus_oe_nxt  = r_bus_oe;
    w_owner_nxt   = r_owner;
    w_preempt_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_winner_nxt  = w_pick_idx;
          w_busrq_n_nxt = 1'b0;
          w_state_nxt   = REQ;
        end
      end
      REQ: begin
        // A requester that gives up before the ack aborts the whole request.
        if (!req[r_winner]) begin
          w_busrq_n_nxt = 1'b1;
          w_state_nxt   = RELEASE;
        end else if (!nBUSACK) begin
          w_grant_nxt  = NREQ'(onehot(OWNER_W_MAX'(r_winner)));
          w_bus_oe_nxt = 1'b1;
          w_owner_nxt  = r_winner;
          w_hold_nxt   = '0;
          w_state_nxt  = GRANT;
        end
      end
      GRANT: begin
        if (!req[r_owner] || w_expire) begin
          w_grant_nxt   = '0;
          w_bus_oe_nxt  = 1'b0;
          w_busrq_n_nxt = 1'b1;
          w_ptr_nxt     = (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + OW'(1);
          w_preempt_nxt = req[r_owner];
          w_state_nxt   = RELEASE;
        end else begin
          w_hold_nxt = r_hold_cnt + HW'(1);
        end
      end
      RELEASE: begin
        if (nBUSACK) begin
          w_gap_nxt   = '0;
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (r_gap_cnt == GW'(MIN_CPU - 1)) begin
          w_state_nxt = IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt + GW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign nBUSRQ  = r_busrq_n;
  assign grant   = r_grant;
  assign bus_oe  = r_bus_oe;
  assign owner   = r_owner;
  assign preempt = r_preempt;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// tb/tb_z80_bus_arbiter.sv - self-checking bench for z80_bus_arbiter
module tb_z80_bus_arbiter;

  localparam int NREQ     = 2;
  localparam int MAX_HOLD = 8;
  localparam int MIN_CPU  = 4;
  localparam int OW       = z80_arb_pkg::owner_w(NREQ);

  localparam int P_IDLE = 0, P_ASK = 1, P_OWN = 2, P_REL = 3, P_GAP = 4;

  logic            CLK = 1'b0;
  logic            RESET = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic            nBUSACK = 1'b1;
  logic            nBUSRQ;
  logic [NREQ-1:0] grant;
  logic            bus_oe;
  logic [OW-1:0]   owner;
  logic            preempt;

  int n_checks = 0;
  int n_errors = 0;

  bit auto_cpu = 0;
  bit spur_en  = 0;
  int ack_max  = 2;
  int cpu_wait = 0;

  z80_bus_arbiter #(
    .NREQ     (NREQ),
    .MAX_HOLD (MAX_HOLD),
    .MIN_CPU  (MIN_CPU)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .req     (req),
    .nBUSACK (nBUSACK),
    .nBUSRQ  (nBUSRQ),
    .grant   (grant),
    .bus_oe  (bus_oe),
    .owner   (owner),
    .preempt (preempt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs as the DUT saw them at the last rising edge.
  logic            c_rst = 1'b1;
  logic            c_ack = 1'b1;
  logic [NREQ-1:0] c_req = '0;
  logic            c_valid = 1'b0;
  always @(posedge CLK) begin
    c_rst   <= RESET;
    c_req   <= req;
    c_ack   <= nBUSACK;
    c_valid <= 1'b1;
  end

  // Reference model: phase, tenure length so far, GAP cycles remaining.
  int ph = P_IDLE;
  int m_win = 0, m_owner = 0, m_ptr = 0, tenure = 0, gap_left = 0;
  bit m_busrq_n = 1, m_has = 0, m_pre = 0;

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  task automatic model_step();
    m_pre = 0;
    if (c_rst) begin
      ph = P_IDLE; m_busrq_n = 1; m_has = 0; m_owner = 0; m_ptr = 0;
    end else begin
      case (ph)
        P_IDLE: if (c_req != 0) begin
          m_win = pick(c_req, m_ptr); m_busrq_n = 0; ph = P_ASK;
        end
        P_ASK: if (!c_req[m_win]) begin
          m_busrq_n = 1; ph = P_REL;
        end else if (!c_ack) begin
          m_has = 1; m_owner = m_win; tenure = 1; ph = P_OWN;
        end
        P_OWN: if (!c_req[m_owner] || tenure == MAX_HOLD) begin
          m_pre = c_req[m_owner]; m_has = 0; m_busrq_n = 1;
          m_ptr = (m_owner + 1) % NREQ; ph = P_REL;
        end else tenure++;
        P_REL: if (c_ack) begin gap_left = MIN_CPU; ph = P_GAP; end
        default: begin gap_left--; if (gap_left == 0) ph = P_IDLE; end
      endcase
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (c_valid) begin
        model_step();
        chk("nBUSRQ", int'(nBUSRQ), int'(m_busrq_n));
        chk("grant", int'(grant), m_has ? (1 << m_owner) : 0);
        chk("bus_oe", int'(bus_oe), int'(m_has));
        chk("owner", int'(owner), m_owner);
        chk("preempt", int'(preempt), int'(m_pre));
        chk("onehot0", int'($onehot0(grant)), 1);
        if (grant != 0) begin
          chk("grant_busrq_low", int'(nBUSRQ), 0);
          chk("grant_prev_ack_low", int'(c_ack), 0);
        end
      end
    end
  end

  task automatic cpu_drive();
    if (nBUSACK != nBUSRQ) begin
      if (cpu_wait == 0) begin
        nBUSACK  = nBUSRQ;
        cpu_wait = $urandom_range(0, ack_max);
      end else cpu_wait--;
    end else if (spur_en && nBUSRQ && $urandom_range(0, 15) == 0) begin
      nBUSACK = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (auto_cpu) cpu_drive();
  endtask

  logic [NREQ-1:0] tv [3];
  int              to [3];
  int              tl [3];
  int              tp [3];

  initial begin
    int nt, len, bad;
    logic [NREQ-1:0] pg;

    repeat (3) step();
    chk("rst_nBUSRQ", int'(nBUSRQ), 1);
    chk("rst_grant", int'(grant), 0);
    chk("rst_bus_oe", int'(bus_oe), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_preempt", int'(preempt), 0);

    // Single master; cycle 0 starts here.
    RESET = 0; req = 2'b01;
    step();                                          // 1
    chk("t1_busrq_c1", int'(nBUSRQ), 0);
    chk("t1_grant_c1", int'(grant), 0);
    step(); step();                                  // 3
    nBUSACK = 0;
    chk("t1_grant_c3", int'(grant), 0);
    step();                                          // 4
    chk("t1_grant_c4", int'(grant), 1);
    chk("t1_oe_c4", int'(bus_oe), 1);
    chk("t1_owner_c4", int'(owner), 0);
    repeat (6) step();                               // 10
    chk("t1_grant_c10", int'(grant), 1);
    req = 2'b00;
    step();                                          // 11
    chk("t1_grant_c11", int'(grant), 0);
    chk("t1_busrq_c11", int'(nBUSRQ), 1);
    chk("t1_preempt_c11", int'(preempt), 0);
    step();                                          // 12
    nBUSACK = 1;
    repeat (3) step();                               // 15, inside GAP
    req = 2'b10;
    step(); step();                                  // 17
    chk("t1_gap_busrq_c17", int'(nBUSRQ), 1);
    step();                                          // 18
    chk("t1_idle_busrq_c18", int'(nBUSRQ), 0);

    // Abort: winner 1 drops before any ack.
    req = 2'b00;
    step();                                          // 19
    chk("ab_busrq_c19", int'(nBUSRQ), 1);
    chk("ab_grant_c19", int'(grant), 0);
    repeat (4) step();                               // 23
    req = 2'b10;
    step();                                          // 24
    chk("ab_busrq_c24", int'(nBUSRQ), 1);
    step();                                          // 25
    chk("ab_busrq_c25", int'(nBUSRQ), 0);

    // Slow ack: 50 cycles with nBUSACK high.
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (grant != 0 || nBUSRQ != 0) bad++;
    end
    chk("slow_no_grant", bad, 0);
    nBUSACK = 0;
    chk("slow_grant_same_cycle", int'(grant), 0);
    step();
    chk("slow_grant", int'(grant), 2);
    chk("slow_owner", int'(owner), 1);
    chk("slow_oe", int'(bus_oe), 1);

    // Reset mid-tenure.
    step(); step();
    RESET = 1;
    step();
    chk("mrst_grant", int'(grant), 0);
    chk("mrst_oe", int'(bus_oe), 0);
    chk("mrst_busrq", int'(nBUSRQ), 1);
    chk("mrst_owner", int'(owner), 0);
    RESET = 0;
    step();
    chk("mrst_rereq", int'(nBUSRQ), 0);

    auto_cpu = 1; ack_max = 2; req = 2'b00;
    repeat (20) step();

    // Contention from a fresh pointer.
    RESET = 1; step(); step(); RESET = 0;
    req = 2'b11;
    nt = 0; len = 0; pg = '0;
    for (int cyc = 0; cyc < 300 && nt < 3; cyc++) begin
      step();
      if (grant != 0 && pg == 0) begin
        tv[nt] = grant; to[nt] = int'(owner); len = 1;
      end else if (grant != 0) begin
        len++;
      end else if (pg != 0) begin
        tl[nt] = len; tp[nt] = int'(preempt); nt++;
      end
      pg = grant;
    end
    chk("cont_tenures", nt, 3);
    for (int i = 0; i < nt; i++) begin
      chk($sformatf("cont_grant_%0d", i), int'(tv[i]), (i % 2 == 0) ? 1 : 2);
      chk($sformatf("cont_owner_%0d", i), to[i], i % 2);
      chk($sformatf("cont_len_%0d", i), tl[i], MAX_HOLD);
      chk($sformatf("cont_preempt_%0d", i), tp[i], 1);
    end

    // Randomized traffic with spurious acks and rare resets.
    req = 2'b00; spur_en = 1; ack_max = 4;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 5) == 0) req[i] = 1'b1;
        end else if ($urandom_range(0, 11) == 0) begin
          req[i] = 1'b0;
        end
      end
      RESET = ($urandom_range(0, 499) == 0);
      step();
    end
    RESET = 0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/z80_bus_arbiter.md
Name: z80_bus_arbiter

Overview:
Owns the Z80 bus-request handshake (nBUSRQ/nBUSACK) on behalf of up to NREQ external bus masters, for example DMA or video fetch.
- Picks one requester round-robin and requests the bus from the CPU.
- Grants the bus only once the CPU acknowledges.
- Bounds each tenure with MAX_HOLD cycles.
- Guarantees the CPU MIN_CPU cycles of ownership between tenures.
- Sits beside the CPU top level, on the same clock as the CPU pins.

Parameters:
NREQ, 2, number of requesting masters (1..8)
MAX_HOLD, 64, maximum cycles a master holds the bus per tenure (>=1)
MIN_CPU, 4, minimum cycles the CPU owns the bus after release before the next request (>=1)

Ports:
CLK  in  1  CPU clock, same net as the CPU CLK pin
RESET  in  1  synchronous, active-high reset
req  in  NREQ  per-master bus request, level, held until grant plus done
nBUSACK  in  1  CPU bus-acknowledge pin, active low, sampled on CLK
nBUSRQ  out  1  to CPU bus-request pin, active low, registered
grant  out  NREQ  one-hot grant, registered; master may drive A/D/control only while its bit is high
bus_oe  out  1  OR of grant; enables the external-master pin drivers
owner  out  $clog2(NREQ) (min 1)  index of current/last granted master
preempt  out  1  one-cycle pulse when a tenure ends by MAX_HOLD expiry

Behaviour:
- Interface: one clock, CLK; reset is synchronous and active-high (RESET). All outputs are registered.
- Reset values: nBUSRQ=1, grant=0, bus_oe=0, owner=0, preempt=0, state=IDLE, hold_cnt=0, gap_cnt=0, rr pointer=0. Reset asserted in any state returns all outputs to these values at the next edge, including mid-tenure. The bus is released immediately and the master loses grant without notice.
- States: IDLE, REQ, GRANT, RELEASE, GAP.
- IDLE: if |req, latch winner = first set bit at or after rr pointer (wrapping modulo NREQ). Go to REQ; nBUSRQ=0 from the next edge (1-cycle latency from req to nBUSRQ).
- REQ: on sampled nBUSACK=0 with req[winner]=1, go to GRANT. grant[winner]=1, bus_oe=1, owner=winner, hold_cnt=0. Grant appears 1 cycle after nBUSACK is seen low.
- REQ abort: if req[winner] drops before nBUSACK=0, go to RELEASE (nBUSRQ=1). No grant is issued.
- GRANT: hold_cnt increments each cycle.
  - Exit when req[owner]=0 or hold_cnt==MAX_HOLD-1.
  - Next edge: grant=0, bus_oe=0, nBUSRQ=1, rr pointer=owner+1 mod NREQ.
  - preempt=1 for one cycle only if exit was by expiry with req[owner] still 1.
  - If both conditions coincide, the exit is treated as a voluntary drop (no preempt).
- RELEASE: wait for sampled nBUSACK=1, then go to GAP with gap_cnt=0. No new grant may occur while nBUSACK=0.
- GAP: count MIN_CPU cycles, then go to IDLE. Requests arriving during GAP are served only from IDLE. A preempted master still requesting competes normally but has lowest priority.
- Other guarantees:
  - grant is never nonzero while nBUSRQ=1.
  - grant is never nonzero in the same cycle nBUSACK is first seen low.
  - At most one grant bit is set.
- Request changes: new req bits during REQ/GRANT do not change winner/owner.
- Spurious nBUSACK=0 while IDLE/GAP: ignored.

Decomposition:
- Shared package z80_arb_pkg holds:
  - state enum arb_state_t {IDLE, REQ, GRANT, RELEASE, GAP};
  - function onehot(idx) returning the NREQ-wide one-hot vector;
  - localparam for owner width.
- One sub-module: rr_pick (combinational round-robin picker).
  - Inputs: req[NREQ-1:0], ptr.
  - Outputs: valid, idx.

Test Plan:
- Single master, NREQ=2, MAX_HOLD=64, MIN_CPU=4: req[0]=1 at cycle 0 → nBUSRQ=0 at cycle 1. Drive nBUSACK=0 at cycle 3 → grant=2'b01, bus_oe=1 at cycle 4. Drop req[0] at cycle 10 → grant=0, nBUSRQ=1 at cycle 11. nBUSACK=1 at cycle 12 → back in IDLE at cycle 17.
- Contention: req=2'b11 held continuously, MAX_HOLD=8 → grants alternate 01,10,01. Each tenure lasts exactly 8 cycles with a preempt pulse at each end. owner toggles 0,1,0.
- Abort: req[1]=1, drop it before nBUSACK falls → grant never asserts, nBUSRQ returns to 1, arbiter reaches IDLE after nBUSACK=1 plus 4 GAP cycles.
- Slow ack: nBUSACK held 1 for 50 cycles after nBUSRQ=0 → grant stays 0 throughout, then grant asserts exactly 1 cycle after nBUSACK=0.
- Reset mid-tenure: RESET=1 during GRANT → next edge grant=0, bus_oe=0, nBUSRQ=1, owner=0. req still high after RESET=0 → nBUSRQ=0 one cycle later.
- Invariants (assertions, all runs): $onehot0(grant); grant!=0 implies nBUSRQ==0 and nBUSACK was 0 the previous cycle.
